// File: rtl/fcnn_seq.sv
`default_nettype none
// =============================================================================
// fcnn_seq : two-layer fully-connected network evaluated on one shared signed
//            MAC, biases/weights streamed from external sync memory. Rev 1.0
// =============================================================================
module fcnn_seq #(
    parameter int NoInputs  = 784,
    parameter int NoHidden  = 30,
    parameter int NoOutputs = 10,
    parameter int dataWidth = 16,
    parameter int fracBits  = 8,
    parameter int OutRelu   = 0,
    parameter int addrWidth = $clog2(NoHidden*(NoInputs+1) + NoOutputs*(NoHidden+1))
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           start,
    input  logic [NoInputs*dataWidth-1:0]  iData,
    output logic [addrWidth-1:0]           wAddr,
    input  logic [dataWidth-1:0]           wData,
    output logic                           busy,
    output logic                           done,
    output logic [NoOutputs*dataWidth-1:0] oData,
    output logic [$clog2(NoOutputs)-1:0]   oClass
);
    localparam int W    = dataWidth;
    localparam int MAXP = (NoInputs > NoHidden) ? NoInputs : NoHidden;
    localparam int MAXN = (NoHidden > NoOutputs) ? NoHidden : NoOutputs;
    localparam int AW   = 2*W + $clog2(MAXP+1);
    localparam int CW   = $clog2(MAXP+3);
    localparam int NW   = $clog2(MAXN+1);
    localparam int CLW  = $clog2(NoOutputs);

    localparam logic [CW-1:0]        P0     = CW'(NoInputs);
    localparam logic [CW-1:0]        P1     = CW'(NoHidden);
    localparam logic [NW-1:0]        LASTN0 = NW'(NoHidden-1);
    localparam logic [NW-1:0]        LASTN1 = NW'(NoOutputs-1);
    localparam logic signed [AW-1:0] SAT_HI = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_L0   = 3'd2,
        S_L1   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          c_q, c_d;
    logic [NW-1:0]          n_q, n_d;
    logic [addrWidth-1:0]   addr_q, addr_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [W-1:0]    in_q  [NoInputs];
    logic signed [W-1:0]    in_d  [NoInputs];
    logic signed [W-1:0]    hid_q [NoHidden];
    logic signed [W-1:0]    hid_d [NoHidden];
    logic signed [W-1:0]    out_q [NoOutputs];
    logic signed [W-1:0]    out_d [NoOutputs];
    logic [NoOutputs*W-1:0] odata_q, odata_d;
    logic [CLW-1:0]         class_q, class_d;

    logic [CW-1:0]          p_cur;
    logic [NW-1:0]          n_last;
    logic                   wb;
    logic                   fin;
    logic signed [W-1:0]    x_cur;
    logic signed [W-1:0]    res;
    logic signed [2*W-1:0]  prod;
    logic signed [AW-1:0]   shifted;
    logic signed [W-1:0]    best;
    logic [CLW-1:0]         best_idx;

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        n_d     = n_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        in_d    = in_q;
        hid_d   = hid_q;
        out_d   = out_q;
        odata_d = odata_q;
        class_d = class_q;
        fin     = 1'b0;

        p_cur  = (state_q == S_L1) ? P1 : P0;
        n_last = (state_q == S_L1) ? LASTN1 : LASTN0;
        wb     = (c_q == p_cur + CW'(2));
        // Operand buffers rotate one place per MAC, so the current operand is always at index 0
        x_cur  = (state_q == S_L1) ? hid_q[0] : in_q[0];
        prod   = $signed({{W{wData[W-1]}}, wData}) * $signed({{W{x_cur[W-1]}}, x_cur});

        shifted = acc_q >>> fracBits;
        if (shifted > SAT_HI)
            res = SAT_HI[W-1:0];
        else if (shifted < SAT_LO)
            res = SAT_LO[W-1:0];
        else
            res = shifted[W-1:0];
        if ((state_q == S_L0 || OutRelu != 0) && res[W-1])
            res = '0;

        case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                for (int k = 0; k < NoInputs; k++)
                    in_d[k] = iData[k*W +: W];
                c_d     = '0;
                n_d     = '0;
                addr_d  = '0;
                state_d = S_L0;
            end
            S_L0, S_L1: begin
                c_d = c_q + 1'b1;
                if (c_q < p_cur)
                    addr_d = addr_q + 1'b1;
                if (c_q == CW'(1)) begin
                    acc_d = $signed({{(AW-W){wData[W-1]}}, wData}) <<< fracBits;
                end else if (wb) begin
                    c_d = '0;
                    // Results shift in from the top, so neuron 0 ends up at index 0
                    if (state_q == S_L0) begin
                        for (int k = 0; k < NoHidden-1; k++)
                            hid_d[k] = hid_q[k+1];
                        hid_d[NoHidden-1] = res;
                    end else begin
                        for (int k = 0; k < NoOutputs-1; k++)
                            out_d[k] = out_q[k+1];
                        out_d[NoOutputs-1] = res;
                    end
                    if (n_q == n_last) begin
                        n_d = '0;
                        if (state_q == S_L0) begin
                            state_d = S_L1;
                            addr_d  = addr_q + 1'b1;
                        end else begin
                            state_d = S_DONE;
                            fin     = 1'b1;
                        end
                    end else begin
                        n_d    = n_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end else if (c_q > CW'(1)) begin
                    acc_d = acc_q + $signed({{(AW-2*W){prod[2*W-1]}}, prod});
                    if (state_q == S_L0) begin
                        for (int k = 0; k < NoInputs-1; k++)
                            in_d[k] = in_q[k+1];
                        in_d[NoInputs-1] = in_q[0];
                    end else begin
                        for (int k = 0; k < NoHidden-1; k++)
                            hid_d[k] = hid_q[k+1];
                        hid_d[NoHidden-1] = hid_q[0];
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        best     = out_d[0];
        best_idx = '0;
        for (int k = 1; k < NoOutputs; k++) begin
            if (out_d[k] > best) begin
                best     = out_d[k];
                best_idx = CLW'(k);
            end
        end
        if (fin) begin
            for (int k = 0; k < NoOutputs; k++)
                odata_d[k*W +: W] = out_d[k];
            class_d = best_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            in_q    <= '{default: '0};
            hid_q   <= '{default: '0};
            out_q   <= '{default: '0};
            odata_q <= '0;
            class_q <= '0;
        end else if (enable) begin
            state_q <= state_d;
            c_q     <= c_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            in_q    <= in_d;
            hid_q   <= hid_d;
            out_q   <= out_d;
            odata_q <= odata_d;
            class_q <= class_d;
        end
    end

    assign wAddr  = addr_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign oData  = odata_q;
    assign oClass = class_q;

endmodule
`default_nettype wire

// File: tb/tb_fcnn_seq.sv
`default_nettype none
// tb_fcnn_seq : directed self-checking bench for fcnn_seq (I=H=O=4, W=16, F=8).
`timescale 1ns/1ps
module tb_fcnn_seq;
    localparam int I   = 4;
    localparam int H   = 4;
    localparam int O   = 4;
    localparam int W   = 16;
    localparam int F   = 8;
    localparam int MEM = H*(I+1) + O*(H+1);
    localparam int AWD = $clog2(MEM);

    logic           clk    = 1'b0;
    logic           rst    = 1'b1;
    logic           enable = 1'b1;
    logic           start  = 1'b0;
    logic [I*W-1:0] iData  = '0;
    logic [AWD-1:0] wAddr;
    logic [W-1:0]   wData  = '0;
    logic           busy;
    logic           done;
    logic [O*W-1:0] oData;
    logic [1:0]     oClass;
    logic [W-1:0]   mem [0:MEM-1];
    int             checks = 0;
    int             errors = 0;

    localparam logic [O*W-1:0] ID_VEC = {16'h0300, 16'h0080, 16'h0200, 16'h0100};

    fcnn_seq #(
        .NoInputs (I),
        .NoHidden (H),
        .NoOutputs(O),
        .dataWidth(W),
        .fracBits (F),
        .OutRelu  (0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .start (start),
        .iData (iData),
        .wAddr (wAddr),
        .wData (wData),
        .busy  (busy),
        .done  (done),
        .oData (oData),
        .oClass(oClass)
    );

    always #5 clk = ~clk;

    // Synchronous parameter memory; holds its output while the pipeline is stalled
    always @(posedge clk) if (enable) wData <= mem[wAddr];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_mem();
        for (int a = 0; a < MEM; a++) mem[a] = '0;
    endtask

    task automatic set_w(input int layer, input int n, input int idx, input logic [W-1:0] v);
        int base;
        base = (layer == 0) ? n*(I+1) : H*(I+1) + n*(H+1);
        mem[base + idx + 1] = v;
    endtask

    task automatic load_identity();
        clear_mem();
        for (int j = 0; j < 4; j++) begin
            set_w(0, j, j, 16'h0100);
            set_w(1, j, j, 16'h0100);
        end
    endtask

    task automatic run_plain(output int lat, output logic busy1, output logic [O*W-1:0] od_pre);
        int t;
        repeat (2) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy1  = busy;
        od_pre = oData;
        t      = 1;
        lat    = -1;
        while (t < 400 && lat < 0) begin
            od_pre = oData;
            @(posedge clk);
            #1 t++;
            if (done) lat = t;
        end
    endtask

    function automatic bit in_burst(input int t);
        return (t >= 3 && t <= 7) || (t >= 12 && t <= 23) || (t >= 30 && t <= 36) || (t >= 45 && t <= 57);
    endfunction

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (wAddr !== '0) begin errors++; $display("FAIL reset_waddr: got %0h want 0", wAddr); end
        checks++; if (oData !== '0) begin errors++; $display("FAIL reset_odata: got %h want 0", oData); end
        checks++; if (oClass !== 2'd0) begin errors++; $display("FAIL reset_oclass: got %0d want 0", oClass); end
        rst = 1'b0;
    endtask

    task automatic test_identity();
        int lat; logic b1; logic [O*W-1:0] pre;
        load_identity();
        iData = ID_VEC;
        run_plain(lat, b1, pre);
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL identity_busy_rise: got %b want 1", b1); end
        checks++; if (pre !== '0) begin errors++; $display("FAIL identity_odata_hold: got %h want 0", pre); end
        checks++; if (lat !== 58) begin errors++; $display("FAIL identity_latency: got %0d want 58", lat); end
        checks++; if (oData !== ID_VEC) begin errors++; $display("FAIL identity_odata: got %h want %h", oData, ID_VEC); end
        checks++; if (oClass !== 2'd3) begin errors++; $display("FAIL identity_oclass: got %0d want 3", oClass); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL identity_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_bias_relu();
        int lat; logic b1; logic [O*W-1:0] pre;
        logic [O*W-1:0] exp_v;
        load_identity();
        set_w(0, 0, -1, 16'hFB00);
        set_w(1, 0, -1, 16'hFE80);
        iData = ID_VEC;
        exp_v = {16'h0300, 16'h0080, 16'h0200, 16'hFE80};
        run_plain(lat, b1, pre);
        checks++; if (oData !== exp_v) begin errors++; $display("FAIL bias_relu_odata: got %h want %h", oData, exp_v); end
        checks++; if (oClass !== 2'd3) begin errors++; $display("FAIL bias_relu_oclass: got %0d want 3", oClass); end
    endtask

    task automatic test_saturation();
        int lat; logic b1; logic [O*W-1:0] pre;
        logic [O*W-1:0] exp_v;
        for (int a = 0; a < MEM; a++) mem[a] = 16'h7F00;
        for (int j = 0; j < 4; j++) begin
            set_w(0, j, -1, 16'h0000);
            set_w(1, j, -1, 16'h0000);
        end
        iData = {4{16'h7F00}};
        exp_v = {4{16'h7FFF}};
        run_plain(lat, b1, pre);
        checks++; if (oData !== exp_v) begin errors++; $display("FAIL sat_pos_odata: got %h want %h", oData, exp_v); end
        checks++; if (oClass !== 2'd0) begin errors++; $display("FAIL sat_pos_oclass: got %0d want 0", oClass); end
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                set_w(1, k, j, 16'h8100);
        exp_v = {4{16'h8000}};
        run_plain(lat, b1, pre);
        checks++; if (oData !== exp_v) begin errors++; $display("FAIL sat_neg_odata: got %h want %h", oData, exp_v); end
    endtask

    task automatic test_argmax_tie();
        int lat; logic b1; logic [O*W-1:0] pre;
        logic [O*W-1:0] v;
        load_identity();
        v = {16'h0100, 16'h0500, 16'h0500, 16'h0200};
        iData = v;
        run_plain(lat, b1, pre);
        checks++; if (oData !== v) begin errors++; $display("FAIL tie_odata: got %h want %h", oData, v); end
        checks++; if (oClass !== 2'd1) begin errors++; $display("FAIL tie_oclass: got %0d want 1", oClass); end
    endtask

    task automatic test_floor();
        int lat; logic b1; logic [O*W-1:0] pre;
        logic [O*W-1:0] exp_v;
        load_identity();
        set_w(1, 0, 0, 16'hFF80);
        iData = {16'h0000, 16'h0000, 16'h0100, 16'h0001};
        exp_v = {16'h0000, 16'h0000, 16'h0100, 16'hFFFF};
        run_plain(lat, b1, pre);
        checks++; if (oData !== exp_v) begin errors++; $display("FAIL floor_odata: got %h want %h", oData, exp_v); end
        checks++; if (oClass !== 2'd1) begin errors++; $display("FAIL floor_oclass: got %0d want 1", oClass); end
    endtask

    task automatic test_stall();
        int t; int lat; logic [AWD-1:0] a_before;
        load_identity();
        iData = ID_VEC;
        repeat (2) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t = 1; lat = -1;
        while (t < 400 && lat < 0) begin
            enable   = !in_burst(t);
            a_before = wAddr;
            @(posedge clk);
            #1;
            if (!enable) begin
                checks++;
                if (wAddr !== a_before) begin errors++; $display("FAIL stall_waddr t=%0d: got %0h want %0h", t, wAddr, a_before); end
            end
            t++;
            if (done) lat = t;
        end
        enable = 1'b1;
        checks++; if (lat !== 95) begin errors++; $display("FAIL stall_latency: got %0d want 95", lat); end
        checks++; if (oData !== ID_VEC) begin errors++; $display("FAIL stall_odata: got %h want %h", oData, ID_VEC); end
        checks++; if (oClass !== 2'd3) begin errors++; $display("FAIL stall_oclass: got %0d want 3", oClass); end
        enable = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done_hold: got %b want 1", done); end
        end
        enable = 1'b1;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_done_release: got %b want 0", done); end
    endtask

    task automatic test_control();
        int t; int lat; logic b1; logic [O*W-1:0] pre;
        logic [O*W-1:0] v2;
        load_identity();
        iData = ID_VEC;
        repeat (2) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t = 1; lat = -1;
        while (t < 400 && lat < 0) begin
            start = (t == 10);
            @(posedge clk);
            #1 t++;
            if (done) lat = t;
        end
        start = 1'b0;
        checks++; if (lat !== 58) begin errors++; $display("FAIL ctrl_ignore_start_latency: got %0d want 58", lat); end
        checks++; if (oData !== ID_VEC) begin errors++; $display("FAIL ctrl_ignore_start_odata: got %h want %h", oData, ID_VEC); end

        repeat (2) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t = 1;
        while (t < 40) begin
            @(posedge clk);
            #1 t++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ctrl_rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ctrl_rst_done: got %b want 0", done); end
        checks++; if (oData !== '0) begin errors++; $display("FAIL ctrl_rst_odata: got %h want 0", oData); end
        checks++; if (oClass !== 2'd0) begin errors++; $display("FAIL ctrl_rst_oclass: got %0d want 0", oClass); end
        checks++; if (wAddr !== '0) begin errors++; $display("FAIL ctrl_rst_waddr: got %0h want 0", wAddr); end

        v2 = {16'h0200, 16'h0400, 16'h0100, 16'h0040};
        iData = v2;
        run_plain(lat, b1, pre);
        checks++; if (pre !== '0) begin errors++; $display("FAIL ctrl_after_rst_hold: got %h want 0", pre); end
        checks++; if (lat !== 58) begin errors++; $display("FAIL ctrl_after_rst_latency: got %0d want 58", lat); end
        checks++; if (oData !== v2) begin errors++; $display("FAIL ctrl_after_rst_odata: got %h want %h", oData, v2); end
        checks++; if (oClass !== 2'd2) begin errors++; $display("FAIL ctrl_after_rst_oclass: got %0d want 2", oClass); end
    endtask

    task automatic test_back_to_back();
        int t; int t1; int t2; logic b_idle;
        load_identity();
        iData = ID_VEC;
        repeat (2) @(posedge clk);
        @(negedge clk) start = 1'b1;
        t = 0; t1 = -1; t2 = -1; b_idle = 1'bx;
        while (t < 400 && t2 < 0) begin
            @(posedge clk);
            #1 t++;
            if (done) begin
                if (t1 < 0) t1 = t;
                else t2 = t;
            end
            if (t1 > 0 && t == t1 + 1) b_idle = busy;
        end
        start = 1'b0;
        checks++; if (t1 !== 58) begin errors++; $display("FAIL b2b_first_done: got %0d want 58", t1); end
        checks++; if (t2 - t1 !== 59) begin errors++; $display("FAIL b2b_gap: got %0d want 59", t2 - t1); end
        checks++; if (b_idle !== 1'b0) begin errors++; $display("FAIL b2b_busy_idle: got %b want 0", b_idle); end
        checks++; if (oData !== ID_VEC) begin errors++; $display("FAIL b2b_odata: got %h want %h", oData, ID_VEC); end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_identity();
        test_bias_relu();
        test_saturation();
        test_argmax_tie();
        test_floor();
        test_stall();
        test_control();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fcnn_seq.md
# fcnn_seq

Time-multiplexed, parametrised two-layer fully-connected network: one signed MAC evaluates every neuron in turn, fetching biases and weights from an external synchronous memory instead of wide parallel buses. It replaces the fully parallel fixed-size network in the classifier datapath. It adds:
- a start/done handshake,
- fixed-point requantisation with saturation,
- a selectable output activation,
- an argmax class output.

## Interface
Parameters:
- `NoInputs`, default 784: input vector length I.
- `NoHidden`, default 30: hidden neurons H.
- `NoOutputs`, default 10: output neurons O.
- `dataWidth`, default 16: signed two's-complement word width W.
- `fracBits`, default 8: fractional bits F of every operand and result.
- `OutRelu`, default 0: output-layer activation. 0 = identity, 1 = ReLU. The hidden layer is always ReLU.
- `addrWidth`, default `$clog2(H*(I+1)+O*(H+1))`: memory address width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous active-high reset.
- `enable` in 1: clock-enable. Low freezes all state.
- `start` in 1: begin an inference. Sampled only in IDLE with enable high.
- `iData` in I×W: input vector, latched on the accepted start.
- `wAddr` out addrWidth: parameter-memory read address.
- `wData` in W: memory read data, valid exactly one cycle after `wAddr`.
- `busy` out 1: high from the accepted start until done.
- `done` out 1: one-cycle pulse when results are valid.
- `oData` out O×W: output activations.
- `oClass` out `$clog2(O)`: index of the maximum `oData` element.

## Operation
- **Memory layout.** Each neuron occupies P+1 consecutive words: the bias first, then weights for previous-layer elements 0..P-1.
  - Layer 0 has P=I, base 0, neuron j at j·(I+1).
  - Layer 1 has P=H, base H·(I+1), neuron k at base+k·(H+1).
- **FSM states.** IDLE, LOAD, L0, L1, DONE.
  - IDLE→LOAD on start & enable. LOAD latches `iData` into the input buffer.
  - LOAD→L0. L0 evaluates hidden neurons 0..H-1 into the hidden buffer.
  - L0→L1. L1 evaluates output neurons 0..O-1 into the output buffer.
  - L1→DONE. In DONE, `oData`/`oClass` are updated, `done`=1, and the FSM returns to IDLE next cycle.
- **Per-neuron sequence** (P+3 cycles, local cycle c):
  - c=0..P: issue address base+c.
  - c=1: acc ← bias << F (sign-extended).
  - c=2..P+1: acc += wData × x[c-2].
  - c=P+2: write-back, no address issued.
- **Arithmetic.**
  - Products are 2W bits signed.
  - acc is 2W+`$clog2(max(I,H)+1)` bits and never overflows.
  - Result = acc >>> F (arithmetic shift, floor), then saturated to [-2^(W-1), 2^(W-1)-1].
  - ReLU then forces negatives to 0.
- **oClass.** Computed at the transition into DONE over the final output buffer. Strict greater-than compare; ties resolve to the lowest index.
- **start while busy.** Ignored; no queuing.
- **enable low.** Holds FSM, counters, acc, `wAddr` and outputs. The memory is expected to hold `wData` for an unchanged address. A stall of any length leaves the result identical and the latency extended by the stall count. `done` remains high across a stall that occurs while in DONE.
- **Reset.** `rst`, including mid-inference, returns to IDLE next edge and discards the partial result. Values after reset: `busy`=0, `done`=0, `wAddr`=0, `oData`=0, `oClass`=0, acc and buffers cleared.

## Timing
- **Latency.** start accepted on edge 0 → `done` high in cycle 2 + H·(I+3) + O·(H+3). For defaults this is 2+30·787+10·33 = 23942.
- **Register timing.**
  - `busy` rises the cycle after the accepted start and falls together with `done`.
  - `oData`/`oClass` change only in the `done` cycle and hold until the next `done` or reset.
- **Back-to-back.** start is first sampled again in the cycle after `done`.
- **Address.** `wAddr` is registered. It changes only in address-issue cycles and holds its last value otherwise.

## Test plan
- **Identity.** I=4, H=4, O=4, F=8; identity weights, zero biases, iData={1.0,2.0,0.5,3.0}. Expect oData equal to the input, oClass=3, done at cycle 2+4·7+4·7=58.
- **Bias/ReLU.** Hidden bias -5.0 on neuron 0 with positive inputs. Expect hidden activation 0. With OutRelu=0, a negative output is passed through (-1.5 → 0xFE80).
- **Saturation.** All weights and inputs 127.0 with W=16. Expect each output 0x7FFF. The mirrored negative case gives 0x8000 with OutRelu=0.
- **Argmax tie.** Outputs {2.0,5.0,5.0,1.0}. Expect oClass=1.
- **Stall.** Random enable-low bursts totalling 37 cycles. Expect results bit-identical to the unstalled run and done 37 cycles later; `wAddr` constant during each stall.
- **Control.** start pulsed mid-L0 is ignored. rst asserted mid-L1 → `busy`/`done`/`oData`=0 next cycle; a following start produces a correct result.
